// File: rtl/mul_unit.sv
// Iterative unsigned N x N shift-and-add multiplier with start/busy/done handshake.
// One partial-product step per clock; the full-width product appears in Y after N run cycles.
//
// state  | meaning
// S_IDLE | waiting for start; Y holds the last product
// S_RUN  | one partial-product step per edge, N edges total
module mul_unit #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] Y,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state;
  logic [2*N-1:0]  acc;
  logic [2*N-1:0]  mcand;
  logic [N-1:0]    mplier;
  logic [CW-1:0]   cnt;
  logic [2*N-1:0]  acc_next;

  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      Y      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= {{N{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Final step: publish the completed sum directly, skipping partial sums in Y.
          if (cnt == CW'(N - 1)) begin
            Y     <= acc_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: stimulus pushes expected products with their due cycle,
// a monitor pops and compares each cycle against done/busy/Y.
module tb_mul_unit;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   A = '0;
  logic [N-1:0]   B = '0;
  logic [2*N-1:0] Y;
  logic           busy;
  logic           done;

  mul_unit #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Y    (Y),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int prod;
    int due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   bstart = 0;
  int   busy_end = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_y = 0;
  bit   started = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs; the model decides whether the upcoming edge accepts start.
  task automatic step(input logic r, input logic st, input int a, input int b);
    int e;
    @(negedge clk);
    rst   = r;
    start = st;
    A     = N'(a);
    B     = N'(b);
    e     = cyc + 1;
    if (r) begin
      q.delete();
      bstart   = e;
      busy_end = e;
    end else if (st && e > busy_end) begin
      exp_t it;
      it.prod  = (a % (1 << N)) * (b % (1 << N));
      it.due   = e + N;
      q.push_back(it);
      bstart   = e;
      busy_end = e + N;
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        started = 1;
        exp_y   = 0;
        chk("reset_done", int'(done), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_y", int'(Y), 0);
      end else if (started) begin
        if (q.size() > 0 && q[0].due == cyc) begin
          exp_t it;
          it = q.pop_front();
          chk("done_pulse", int'(done), 1);
          exp_y = it.prod;
        end else begin
          chk("done_quiet", int'(done), 0);
        end
        chk("busy", int'(busy), int'(cyc >= bstart && cyc < busy_end));
        chk("y", int'(Y), exp_y);
      end
    end
  end

  initial begin : stim
    // reset held with start asserted, then released idle
    step(1, 1, 5, 3);
    step(1, 1, 5, 3);
    repeat (3) step(0, 0, 5, 3);

    // exhaustive with operands scrambled during busy
    for (int a = 0; a < (1 << N); a++) begin
      for (int b = 0; b < (1 << N); b++) begin
        step(0, 1, a, b);
        repeat (N) step(0, 0, int'($urandom_range(0, (1 << N) - 1)), int'($urandom_range(0, (1 << N) - 1)));
      end
    end

    // operand capture
    step(0, 1, 12, 11);
    repeat (N + 1) step(0, 0, 1, 1);

    // start ignored while busy, including the completing edge
    step(0, 1, 7, 9);
    repeat (N) step(0, 1, 2, 2);
    repeat (2) step(0, 0, 0, 0);

    // abort mid-operation, then a clean multiply
    step(0, 1, 15, 15);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (N + 2) step(0, 0, 0, 0);
    step(0, 1, 6, 7);
    repeat (N + 1) step(0, 0, 0, 0);

    // back-to-back with start held high
    repeat (5 * (N + 1)) step(0, 1, 10, 13);
    repeat (N + 1) step(0, 0, 0, 0);

    // random traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      step(logic'($urandom_range(0, 49) == 0), logic'($urandom_range(0, 2) != 0),
           int'($urandom_range(0, (1 << N) - 1)), int'($urandom_range(0, (1 << N) - 1)));
    end

    repeat (N + 3) step(0, 0, 0, 0);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
